// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared definitions for the instruction fetch stage and the controller that
//   decodes its output: FSM state encoding, the NOP word and the instruction
//   field positions (opcode, funct, jump index).
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // opcode = instr[OPCODE_MSB:OPCODE_LSB], funct = instr[FUNCT_MSB:FUNCT_LSB].
  // The j/jal index field is everything below the opcode.
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// next_pc_sel
//   Combinational next-PC selector. Priority jr > jump > pcsrc > sequential.
//   Ports:
//     pc_plus4       in  32  address of the instruction after the current one
//     instr_index    in  26  j/jal target index (instr[25:0])
//     signimm        in  32  sign-extended branch offset in words
//     jr_target      in  32  rs value for jump register
//     pcsrc/jump/jr  in   1  redirect requests from the controller
//     next_pc        out 32  selected next PC (always word aligned)
//     misaligned_raw out  1  jr requested with a non-word-aligned target
module next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_index,
  input  logic [31:0] signimm,
  input  logic [31:0] jr_target,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic        jr,
  output logic [31:0] next_pc,
  output logic        misaligned_raw
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  always_comb begin
    // Shifting the full word is identical to {signimm[29:0], 2'b00}.
    branch_target  = pc_plus4 + (signimm << 2);
    jump_target    = {pc_plus4[31:28], instr_index, 2'b00};
    misaligned_raw = jr && (jr_target[1:0] != 2'b00);

    next_pc = pc_plus4;
    if (jr) begin
      // Low bits are dropped even when misaligned; the flag reports it.
      next_pc = {jr_target[31:2], 2'b00};
    end else if (jump) begin
      next_pc = jump_target;
    end else if (pcsrc) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage: holds the PC, fetches one word per instruction
//   over a req/ack handshake of any latency, and presents it to the controller
//   until the controller lets it go (stall low).
//   Ports:
//     clk, reset      clock and asynchronous active-high reset
//     pcsrc/jump/jr   redirect requests (honoured only in EXEC)
//     signimm         branch offset, jr_target rs value
//     stall           hold the current instruction in EXEC
//     imem_req/addr   fetch request and address (addr = pc)
//     imem_ack/rdata  memory response (honoured only in FETCH)
//     instr           held instruction, instr_valid while in EXEC
//     pc, pc_plus4    address of instr and its successor (jal link)
//     misaligned      one-cycle pulse after a jr with unaligned target retires
//     instr_count     retired instruction counter (wraps)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] signimm,
  input  logic [31:0] jr_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned,
  output logic [31:0] instr_count
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] pc_plus4_w;
  logic [31:0] next_pc;
  logic        misaligned_raw;
  logic        retire;

  assign pc_plus4_w = pc_q + 32'd4;
  assign retire     = (state_q == EXEC) && !stall;

  next_pc_sel u_next_pc_sel (
    .pc_plus4       (pc_plus4_w),
    .instr_index    (instr_q[OPCODE_LSB-1:0]),
    .signimm        (signimm),
    .jr_target      (jr_target),
    .pcsrc          (pcsrc),
    .jump           (jump),
    .jr             (jr),
    .next_pc        (next_pc),
    .misaligned_raw (misaligned_raw)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (imem_ack) state_d = EXEC;
      EXEC:    if (!stall) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  // Outputs decoded from state only, so imem_ack never reaches imem_req.
  always_comb begin
    imem_req    = (state_q == FETCH);
    instr_valid = (state_q == EXEC);
  end

  // Datapath next values
  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    count_d      = count_q;
    misaligned_d = 1'b0;
    if ((state_q == FETCH) && imem_ack) begin
      instr_d = imem_rdata;
    end
    if (retire) begin
      pc_d         = next_pc;
      count_d      = count_q + 32'd1;
      misaligned_d = misaligned_raw;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      count_q      <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign instr       = instr_q;
  assign misaligned  = misaligned_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed, table-driven check of fetch_unit with RESET_PC = 0x0040_0000.
//   Each table row is one instruction: fetch latency, returned word, redirect
//   inputs, stall length, and the hand-computed fetch address / next PC /
//   misaligned flag. A hand-written sequence covers reset during FETCH.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcsrc, jump, jr, stall;
  logic [31:0] signimm, jr_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr, pc, pc_plus4, instr_count;
  logic        instr_valid, misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .pcsrc       (pcsrc),
    .jump        (jump),
    .jr          (jr),
    .signimm     (signimm),
    .jr_target   (jr_target),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .misaligned  (misaligned),
    .instr_count (instr_count)
  );

  typedef struct {
    int          waits;
    logic [31:0] word;
    logic        v_pcsrc;
    logic        v_jump;
    logic        v_jr;
    logic [31:0] v_signimm;
    logic [31:0] v_jr_target;
    int          stalls;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
    logic        exp_mis;
  } vec_t;

  vec_t tbl [13];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_j(input logic [5:0] op, input logic [25:0] idx);
    logic [31:0] w;
    w = 32'h0;
    w[OPCODE_MSB:OPCODE_LSB] = op;
    w[OPCODE_LSB-1:0] = idx;
    return w;
  endfunction

  function automatic logic [31:0] mk_r(input logic [25:0] mid, input logic [5:0] funct);
    logic [31:0] w;
    w = {6'h00, mid};
    w[FUNCT_MSB:FUNCT_LSB] = funct;
    return w;
  endfunction

  // Called at a negedge with the DUT in FETCH. Redirect and stall inputs are
  // driven to junk throughout to show they are ignored outside EXEC.
  task automatic do_fetch(input int waits, input logic [31:0] word, input logic [31:0] exp_addr);
    for (int i = 0; i <= waits; i++) begin
      chk1("fetch_req", imem_req, 1'b1);
      chk32("fetch_addr", imem_addr, exp_addr);
      chk1("fetch_valid", instr_valid, 1'b0);
      stall = 1'b1; jr = 1'b1; jump = 1'b1; pcsrc = 1'b1;
      jr_target = 32'h1234_5677; signimm = 32'h0000_0100;
      imem_ack   = (i == waits);
      imem_rdata = (i == waits) ? word : 32'hDEAD_BEEF;
      @(negedge clk);
    end
    imem_ack = 1'b0; stall = 1'b0; jr = 1'b0; jump = 1'b0; pcsrc = 1'b0;
    chk32("exec_instr", instr, word);
    chk1("exec_valid", instr_valid, 1'b1);
    chk1("exec_req", imem_req, 1'b0);
    chk1("mis_one_cycle", misaligned, 1'b0);
    chk32("exec_pc", pc, exp_addr);
    chk32("exec_pc4", pc_plus4, exp_addr + 32'd4);
    $display("fetch addr=%08h waits=%0d instr=%08h", exp_addr, waits, instr);
  endtask

  // Called at a negedge with the DUT in EXEC holding word at cur_pc.
  task automatic do_exec(input vec_t v, input logic [31:0] exp_count);
    for (int i = 0; i < v.stalls; i++) begin
      stall = 1'b1;
      pcsrc = v.v_pcsrc; jump = v.v_jump; jr = v.v_jr;
      signimm = v.v_signimm; jr_target = v.v_jr_target;
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;   // ack outside FETCH
      @(negedge clk);
      chk32("stall_pc", pc, v.exp_addr);
      chk32("stall_instr", instr, v.word);
      chk32("stall_count", instr_count, exp_count - 32'd1);
      chk1("stall_req", imem_req, 1'b0);
      chk1("stall_valid", instr_valid, 1'b1);
    end
    stall = 1'b0; imem_ack = 1'b0;
    pcsrc = v.v_pcsrc; jump = v.v_jump; jr = v.v_jr;
    signimm = v.v_signimm; jr_target = v.v_jr_target;
    @(negedge clk);
    pcsrc = 1'b0; jump = 1'b0; jr = 1'b0;
    chk32("next_pc", pc, v.exp_next);
    chk32("count", instr_count, exp_count);
    chk1("misaligned", misaligned, v.exp_mis);
    chk1("exit_valid", instr_valid, 1'b0);
    chk1("exit_req", imem_req, 1'b1);
    $display("exec  pc=%08h next=%08h count=%0d mis=%b", v.exp_addr, pc, instr_count, misaligned);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    //        waits word                        pcs jmp jr  signimm        jr_target      stl addr          next          mis
    tbl[0]  = '{0, mk_r(26'h0012345, 6'h20),   0,  0,  0,  32'h0,         32'h0,         0,  RST_PC,       32'h0040_0004, 0};
    tbl[1]  = '{0, mk_r(26'h0022222, 6'h22),   0,  0,  0,  32'h0,         32'h0,         0,  32'h0040_0004, 32'h0040_0008, 0};
    tbl[2]  = '{0, mk_r(26'h0033333, 6'h24),   0,  0,  0,  32'h0,         32'h0,         0,  32'h0040_0008, 32'h0040_000C, 0};
    tbl[3]  = '{3, 32'h8C01_0004,              0,  0,  0,  32'h0,         32'h0,         0,  32'h0040_000C, 32'h0040_0010, 0};
    tbl[4]  = '{0, mk_r(26'h0000000, 6'h08),   0,  0,  1,  32'h0,         32'h0000_0100, 0,  32'h0040_0010, 32'h0000_0100, 0};
    tbl[5]  = '{0, 32'h1000_FFFE,              1,  0,  0,  32'hFFFF_FFFE, 32'h0,         0,  32'h0000_0100, 32'h0000_00FC, 0};
    tbl[6]  = '{0, mk_r(26'h0000000, 6'h08),   0,  0,  1,  32'h0,         32'h0000_0100, 0,  32'h0000_00FC, 32'h0000_0100, 0};
    tbl[7]  = '{0, mk_j(6'h02, 26'h40),        1,  1,  0,  32'hFFFF_FFFE, 32'h0,         0,  32'h0000_0100, 32'h0000_0100, 0};
    tbl[8]  = '{0, mk_r(26'h0000000, 6'h08),   0,  0,  1,  32'h0,         32'h0000_2003, 4,  32'h0000_0100, 32'h0000_2000, 1};
    tbl[9]  = '{1, mk_j(6'h03, 26'h155),       1,  1,  1,  32'h0000_0010, 32'hFFFF_FFFC, 0,  32'h0000_2000, 32'hFFFF_FFFC, 0};
    tbl[10] = '{0, mk_r(26'h0011111, 6'h25),   0,  0,  0,  32'h0,         32'h0,         0,  32'hFFFF_FFFC, 32'h0000_0000, 0};
    tbl[11] = '{1, 32'h1000_0004,              1,  0,  0,  32'h0000_0004, 32'h0,         0,  32'h0000_0000, 32'h0000_0014, 0};
    tbl[12] = '{0, mk_j(6'h02, 26'h3FF_FFFF),  0,  1,  0,  32'h0,         32'h0,         2,  32'h0000_0014, 32'h0FFF_FFFC, 0};

    reset = 1'b1; pcsrc = 1'b0; jump = 1'b0; jr = 1'b0; stall = 1'b0;
    signimm = 32'h0; jr_target = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    #1;
    chk32("rst_pc", pc, RST_PC);
    chk32("rst_pc4", pc_plus4, RST_PC + 32'd4);
    chk32("rst_instr", instr, 32'h0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_mis", misaligned, 1'b0);
    chk32("rst_count", instr_count, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk1("boot_req", imem_req, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      do_fetch(tbl[i].waits, tbl[i].word, tbl[i].exp_addr);
      do_exec(tbl[i], 32'(i + 1));
    end

    // Reset pulse during FETCH, ack arriving in the following (BOOT) cycle.
    #1;
    reset = 1'b1;
    #1;
    chk1("midrst_req", imem_req, 1'b0);
    chk1("midrst_valid", instr_valid, 1'b0);
    chk32("midrst_pc", pc, RST_PC);
    chk32("midrst_count", instr_count, 32'h0);
    #1;
    reset = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hFEED_FACE;
    @(negedge clk);
    imem_ack = 1'b0;
    chk32("late_ack_instr", instr, 32'h0);
    chk1("late_ack_valid", instr_valid, 1'b0);
    $display("reset during fetch: req=%b addr=%08h count=%0d", imem_req, imem_addr, instr_count);
    do_fetch(0, tbl[0].word, RST_PC);
    do_exec(tbl[0], 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the single-cycle controller. Holds the program counter and fetches each 32-bit instruction from instruction memory over a req/ack handshake with variable latency. Presents the held instruction so the controller can decode `opcode = instr[31:26]` and `funct = instr[5:0]`. Consumes the controller's `pcsrc`/`jump`/`jr` outputs to select the next PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk` in 1: clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `pcsrc` in 1: taken branch, from controller.
- `jump` in 1: j/jal, from controller.
- `jr` in 1: jump register, from controller.
- `signimm` in 32: sign-extended instr[15:0], from the datapath.
- `jr_target` in 32: rs register value.
- `stall` in 1: hold the current instruction in EXEC.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address (= `pc`).
- `imem_ack` in 1: memory returns `imem_rdata` this cycle.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: held instruction.
- `instr_valid` out 1: `instr` is decodable; controller outputs are honoured.
- `pc` out 32: address of `instr`.
- `pc_plus4` out 32: `pc + 4`; the jal link value.
- `misaligned` out 1: one-cycle pulse when `jr_target[1:0] != 0` is taken.
- `instr_count` out 32: retired-instruction counter.

## Operation
- FSM states:
  - BOOT: entered on reset; `imem_req = 0`; goes to FETCH next cycle unconditionally.
  - FETCH: `imem_req = 1`, `imem_addr = pc`. Both stay stable until ack. On a cycle with `imem_ack = 1`, `instr <= imem_rdata` and the FSM goes to EXEC.
  - EXEC: `instr_valid = 1`.
    - If `stall = 1`: remain in EXEC; `pc`, `instr` and the counter are unchanged.
    - Else: `pc <= next_pc`, `instr_count <= instr_count + 1`, and the FSM goes to FETCH.
- `next_pc` priority is `jr` > `jump` > `pcsrc` > sequential:
  - `jr`: `{jr_target[31:2], 2'b00}`.
  - `jump`: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - `pcsrc`: `pc_plus4 + {signimm[29:0], 2'b00}`.
  - otherwise: `pc_plus4`.
- All adds are modulo 2^32; wrap is silent, e.g. `pc = 32'hFFFF_FFFC` advances sequentially to 0.
- `misaligned` pulses in the EXEC-exit cycle when `jr` is taken with nonzero low bits. The target is still forced to word alignment.
- Redirect inputs are ignored outside EXEC.
- `imem_ack` is ignored outside FETCH.
- `instr_count` wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values:
  - `pc = RESET_PC`, `pc_plus4 = RESET_PC + 4`.
  - `instr = 32'h0`, `instr_valid = 0`, `imem_req = 0`, `misaligned = 0`.
  - `instr_count = 0`, state BOOT.
- Outputs are registered or decoded from state only. No combinational path from `imem_ack` to `imem_req`.
- Zero-wait memory (ack in the first FETCH cycle) gives 2 cycles per instruction: FETCH, EXEC.
- With N wait cycles, an instruction takes N+2 cycles.
- `instr_valid` rises the cycle after the ack edge. It falls the cycle after EXEC exits.
- `reset` asserted mid-FETCH or mid-EXEC:
  - immediately drops `imem_req` and `instr_valid`;
  - the outstanding fetch is abandoned;
  - a late ack after reset release is ignored because the FSM is still in BOOT.
- `stall` during FETCH has no effect.

## Structure
- Shared package holds:
  - state encoding (`BOOT`, `FETCH`, `EXEC`, 2 bits);
  - `NOP_INSTR = 32'h0`;
  - opcode field slice constants shared with the controller.
- One combinational sub-module, `next_pc_sel`. Inputs: `pc_plus4`, `instr[25:0]`, `signimm`, `jr_target`, `pcsrc`, `jump`, `jr`. Outputs: `next_pc`, `misaligned_raw`.
- The FSM, registers and counter live in `fetch_unit`.

## Test plan
- Reset with `RESET_PC = 32'h0040_0000` and zero-wait ack:
  - first `imem_addr` is 32'h0040_0000, one cycle after BOOT;
  - subsequent addresses are 0x...04, 0x...08;
  - `instr_valid` is high every other cycle;
  - `instr_count` reaches 3 after 3 EXEC exits.
- Ack delayed 3 cycles:
  - `imem_addr` is stable for 4 cycles;
  - `instr` loads on the ack edge;
  - the instruction takes 5 cycles.
- At `pc = 32'h100`: `pcsrc = 1`, `signimm = 32'hFFFF_FFFE` gives next `pc = 32'hFC`; simultaneous `jump = 1` with `instr[25:0] = 26'h40` gives 32'h100 (jump wins).
- `jr = 1`, `jr_target = 32'h2003` gives next `pc = 32'h2000` and a one-cycle `misaligned` pulse.
- `stall` held 4 cycles in EXEC:
  - `pc`, `instr` and the counter are unchanged;
  - no `imem_req`;
  - the FSM advances on the first cycle with `stall = 0`.
- `reset` pulsed during FETCH with ack arriving in the next cycle: the ack is ignored, fetch restarts at `RESET_PC`, and `instr_count` is 0.
